// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and FSM state encoding for the chunked adder
//   DEF_WIDTH/DEF_CHUNK - default operand width and bits added per cycle
//   state_t             - IDLE (empty), RUN (adding chunks), DONE (result held)
package adder_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/chunked_adder_if.sv
// chunked_adder_if: operand/result handshake bundle for chunked_adder
//   master drives in_valid/a/b/cin/sub/out_ready; slave drives in_ready/out_valid/sum/cout/ovf
interface chunked_adder_if import adder_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
   logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [WIDTH-1:0] a, b, sum;
   modport master(output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout, ovf);
   modport slave(input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/chunk_add.sv
// chunk_add: CHUNK-bit ripple slice used once per clock by chunked_adder
//   a, b, ci -> s (CHUNK-bit sum), co (carry out), cm (carry into the slice MSB)
module chunk_add #(parameter int CHUNK = 4) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             cm
);
   assign {co, s} = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(ci);
   // the MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR
   assign cm = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];
endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/subtract, CHUNK bits per clock, LSB chunk first
//   clk, rst (async, active-high); bus: chunked_adder_if.slave
//   result appears WIDTH/CHUNK edges after accept and is held until out_ready
module chunked_adder import adder_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input logic           clk,
   input logic           rst,
   chunked_adder_if.slave bus
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
   state_t state;
   logic [IW-1:0] idx;
   logic carry, cout_r, ovf_r, co, cm, accept, last;
   logic [WIDTH-1:0] a_r, b_r, sum_r;
   logic [CHUNK-1:0] s;
   chunk_add #(.CHUNK(CHUNK)) u_add (
      .a(a_r[idx*CHUNK +: CHUNK]),
      .b(b_r[idx*CHUNK +: CHUNK]),
      .ci(carry),
      .s(s),
      .co(co),
      .cm(cm)
   );
   assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
   assign bus.out_valid = state == DONE;
   assign bus.sum = sum_r;
   assign bus.cout = cout_r;
   assign bus.ovf = ovf_r;
   assign accept = bus.in_valid && bus.in_ready;
   assign last = idx == IW'(NCH - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         idx <= '0;
         carry <= 1'b0;
         a_r <= '0;
         b_r <= '0;
         sum_r <= '0;
         cout_r <= 1'b0;
         ovf_r <= 1'b0;
      end else if (accept) begin
         // subtraction is A + ~B + ~cin, so borrow-in becomes an inverted carry-in
         a_r <= bus.a;
         b_r <= bus.sub ? ~bus.b : bus.b;
         carry <= bus.cin ^ bus.sub;
         idx <= '0;
         state <= RUN;
      end else if (state == RUN) begin
         sum_r[idx*CHUNK +: CHUNK] <= s;
         carry <= co;
         if (last) begin
            state <= DONE;
            cout_r <= co;
            ovf_r <= cm ^ co;
         end else
            idx <= idx + 1'b1;
      end else if (state == DONE && bus.out_ready)
         state <= IDLE;
endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed and randomized checks of chunked_adder against an arithmetic model
module tb_chunked_adder;
   localparam int W = 16;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int n_cmp = 0, n_err = 0;
   bit ddone = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {ovf, cout, sum} from integer arithmetic on the operands
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
      int u, s;
      u = sub ? int'(a) - int'(b) - int'(cin) : int'(a) + int'(b) + int'(cin);
      s = sub ? int'($signed(a)) - int'($signed(b)) - int'(cin) : int'($signed(a)) + int'($signed(b)) + int'(cin);
      return {s < -32768 || s > 32767, sub ? u >= 0 : u > 65535, u[15:0]};
   endfunction

   logic drst;
   chunked_adder_if #(.WIDTH(W)) dbus();
   chunked_adder #(.WIDTH(W), .CHUNK(4)) u_dut (.clk(clk), .rst(drst), .bus(dbus));

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
      dbus.a = a; dbus.b = b; dbus.cin = cin; dbus.sub = sub; dbus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dbus.in_valid = 1'b0; dbus.out_ready = 1'b0;
      dbus.a = 16'($urandom); dbus.b = 16'($urandom); dbus.cin = 1'($urandom); dbus.sub = 1'($urandom);
   endtask

   task automatic await(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
      int e = 0;
      logic [17:0] m;
      while (!dbus.out_valid && e < 100) begin
         @(posedge clk);
         @(negedge clk);
         e++;
      end
      m = model(a, b, cin, sub);
      check({tag, "_lat"}, e, 4);
      check({tag, "_sum"}, dbus.sum, m[15:0]);
      check({tag, "_cout"}, dbus.cout, m[16]);
      check({tag, "_ovf"}, dbus.ovf, m[17]);
   endtask

   task automatic drain();
      dbus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dbus.out_ready = 1'b0;
   endtask

   initial begin
      int bad;
      drst = 1'b1;
      dbus.in_valid = 1'b0; dbus.out_ready = 1'b0; dbus.a = '0; dbus.b = '0; dbus.cin = 1'b0; dbus.sub = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", dbus.out_valid, 0);
      check("rst_sum", dbus.sum, 0);
      check("rst_cout", dbus.cout, 0);
      check("rst_ovf", dbus.ovf, 0);
      drst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", dbus.in_ready, 1);
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      await("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      check("wrap_sum_k", dbus.sum, 16'h0000);
      check("wrap_cout_k", dbus.cout, 1);
      drain();
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      await("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      check("ovf_sum_k", dbus.sum, 16'h8000);
      check("ovf_ovf_k", dbus.ovf, 1);
      drain();
      issue(16'h0005, 16'h0007, 1'b0, 1'b1);
      await("sub0", 16'h0005, 16'h0007, 1'b0, 1'b1);
      check("sub0_sum_k", dbus.sum, 16'hFFFE);
      drain();
      issue(16'h0005, 16'h0007, 1'b1, 1'b1);
      await("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1);
      check("sub1_sum_k", dbus.sum, 16'hFFFD);
      drain();
      issue(16'h1234, 16'h4321, 1'b0, 1'b0);
      await("hold", 16'h1234, 16'h4321, 1'b0, 1'b0);
      repeat (5) begin
         @(negedge clk);
         check("hold_sum", dbus.sum, 16'h5555);
         check("hold_in_ready", dbus.in_ready, 0);
         check("hold_out_valid", dbus.out_valid, 1);
      end
      dbus.out_ready = 1'b1;
      dbus.a = 16'd1; dbus.b = 16'd2; dbus.cin = 1'b0; dbus.sub = 1'b0; dbus.in_valid = 1'b1;
      #1 check("b2b_in_ready", dbus.in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      dbus.in_valid = 1'b0; dbus.out_ready = 1'b0;
      check("b2b_no_idle_ready", dbus.in_ready, 0);
      check("b2b_no_idle_valid", dbus.out_valid, 0);
      await("b2b", 16'd1, 16'd2, 1'b0, 1'b0);
      check("b2b_sum_k", dbus.sum, 16'h0003);
      drain();
      issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      drst = 1'b1;
      #1 check("abort_out_valid", dbus.out_valid, 0);
      check("abort_sum", dbus.sum, 0);
      @(negedge clk);
      drst = 1'b0;
      #1 check("abort_in_ready", dbus.in_ready, 1);
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (dbus.out_valid) bad++;
      end
      check("abort_no_result", bad, 0);
      issue(16'h1234, 16'h1111, 1'b0, 1'b0);
      await("after_abort", 16'h1234, 16'h1111, 1'b0, 1'b0);
      check("after_abort_sum_k", dbus.sum, 16'h2345);
      drain();
      ddone = 1;
   end

   for (genvar g = 0; g < 3; g++) begin : rnd
      localparam int C = g == 0 ? 1 : g == 1 ? 4 : 16;
      logic rst;
      bit done = 0;
      chunked_adder_if #(.WIDTH(W)) bus();
      chunked_adder #(.WIDTH(W), .CHUNK(C)) u_dut (.clk(clk), .rst(rst), .bus(bus));
      initial begin
         logic [15:0] ra, rb;
         logic rc, rs;
         logic [17:0] m;
         int e;
         rst = 1'b1;
         bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
         repeat (2) @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
         for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = i[0];
            if (i % 10 == 3) ra = 16'h7FFF;
            if (i % 10 == 7) rb = 16'h8000;
            bus.a = ra; bus.b = rb; bus.cin = rc; bus.sub = rs; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            #1 check($sformatf("c%0d_in_ready", C), bus.in_ready, 1);
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom); bus.sub = 1'($urandom);
            bus.in_valid = 1'($urandom);
            e = 0;
            while (!bus.out_valid && e < 100) begin
               @(posedge clk);
               @(negedge clk);
               e++;
               bus.in_valid = 1'($urandom);
            end
            m = model(ra, rb, rc, rs);
            check($sformatf("c%0d_lat", C), e, W / C);
            check($sformatf("c%0d_sum", C), bus.sum, m[15:0]);
            check($sformatf("c%0d_cout", C), bus.cout, m[16]);
            check($sformatf("c%0d_ovf", C), bus.ovf, m[17]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check($sformatf("c%0d_held_sum", C), bus.sum, m[15:0]);
            if ($urandom_range(0, 2) == 0) begin
               bus.in_valid = 1'b0; bus.out_ready = 1'b1;
               @(posedge clk);
               @(negedge clk);
               bus.out_ready = 1'b0;
               check($sformatf("c%0d_idle_valid", C), bus.out_valid, 0);
               check($sformatf("c%0d_idle_ready", C), bus.in_ready, 1);
            end
         end
         bus.in_valid = 1'b0;
         done = 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      wait (ddone && rnd[0].done && rnd[1].done && rnd[2].done);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a positive multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; SHALL satisfy 1 <= CHUNK <= WIDTH.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1  operand set presented.
REQ-006 Port in_ready  output  1  block can accept an operand set this cycle.
REQ-007 Port a  input  WIDTH  operand A, unsigned/two's-complement.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 Port sub  input  1  mode: 0 = A+B+cin, 1 = A-B-cin.
REQ-011 Port out_valid  output  1  result held on outputs.
REQ-012 Port out_ready  input  1  consumer takes result this cycle.
REQ-013 Port sum  output  WIDTH  result bits.
REQ-014 Port cout  output  1  raw carry out of MSB (subtract: 1 = no borrow).
REQ-015 Port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 NCH = WIDTH/CHUNK; state machine states IDLE, RUN, DONE.
REQ-017 in_ready SHALL be 1 in IDLE, and 1 in DONE when out_ready=1; 0 otherwise.
REQ-018 Accept (in_valid & in_ready) SHALL latch a, b, sub; B operand latched as ~b when sub=1; initial carry = cin when sub=0, ~cin when sub=1; chunk index = 0; next state RUN.
REQ-019 Each RUN cycle SHALL add chunk[idx] of A, latched B and running carry, write CHUNK result bits into sum register, update carry, increment idx, LSB chunk first.
REQ-020 After the RUN cycle with idx = NCH-1, next state SHALL be DONE; out_valid SHALL rise exactly NCH clock edges after the accepting edge.
REQ-021 In DONE, sum/cout/ovf SHALL stay stable until out_valid & out_ready.
REQ-022 ovf SHALL equal carry into MSB XOR carry out of MSB; cout SHALL equal final carry.
REQ-023 DONE with out_ready=1 and in_valid=1 SHALL accept the new set same cycle and go directly to RUN (no IDLE bubble); with in_valid=0 go to IDLE.
REQ-024 in_valid during RUN SHALL be ignored (in_ready=0); operands on a/b/cin/sub after accept SHALL not affect the in-flight result.
REQ-025 out_valid SHALL be 1 only in DONE; sum/cout/ovf values outside DONE are don't-care for consumers but SHALL not be X after reset.
REQ-026 CHUNK = WIDTH SHALL yield single-cycle RUN (latency 1); CHUNK = 1 SHALL yield bit-serial operation (latency WIDTH).

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1 after release.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the in-flight operation with no result produced.

Structure
REQ-029 State encoding enum and default WIDTH/CHUNK constants SHALL live in shared package adder_pkg.
REQ-030 One combinational sub-module chunk_add (CHUNK-bit A, B, carry-in -> CHUNK-bit sum, carry-out, carry-into-MSB) SHALL be instantiated once and reused each cycle.
REQ-031 No combinational path from in_valid to out_valid; out_ready to in_ready combinational path permitted.

Verification (WIDTH=16, CHUNK=4)
REQ-032 a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, out_valid 4 edges after accept.
REQ-033 a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-034 a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0; same with cin=1 -> sum=0xFFFD.
REQ-035 out_ready held 0 for 5 cycles in DONE -> sum stable, in_ready=0; then out_ready=1 with in_valid=1 (a=1,b=2) -> next result 0x0003 4 edges later, no IDLE cycle.
REQ-036 rst pulsed at RUN idx=2 -> out_valid never asserts for that operation, in_ready=1 after release, next operation 0x1234+0x1111 -> 0x2345.
REQ-037 Random regression across CHUNK in {1,4,16} and sub in {0,1} vs reference model: sum/cout/ovf match, latency = NCH.
